hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, width of the stall-cycle counter.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 d_valid  input  1  D-stage slot holds a real instruction; 0 = bubble.
REQ-005 d_A1, d_A2  input  5 each  rs/rt read addresses of the D-stage instruction.
REQ-006 d_A3  input  5  destination register of the D-stage instruction.
REQ-007 d_regwrite  input  1  D-stage instruction writes d_A3.
REQ-008 d_tuse_rs, d_tuse_rt  input  3 each  cycles until rs/rt are needed, counted from D; 6 = unused.
REQ-009 d_tnew  input  3  cycles until the result exists, counted from D (lw 3, ALU 2, link 1, none 0).
REQ-010 stall  output  1  freeze PC and the F/D register; insert a bubble into E.
REQ-011 fwd_d_rs, fwd_d_rt  output  2 each  D-stage operand source: 0 regfile, 1 E, 2 M, 3 W.
REQ-012 fwd_e_rs, fwd_e_rt  output  2 each  E-stage operand source: 0 pipeline register, 2 M, 3 W.
REQ-013 stall_cnt  output  CNT_W  number of cycles with stall=1, saturating.

Function
REQ-014 The block SHALL hold one record per stage, E, M and W: {we, A3, tnew[2:0]}. The E record SHALL also hold A1 and A2.
REQ-015 Stage advance on each clk edge with stall=0: E <= {d_valid&d_regwrite, d_A3, dec(d_tnew), d_A1, d_A2}.
REQ-016 Stage advance on each clk edge with stall=1: E <= bubble (all fields 0).
REQ-017 On every clk edge, regardless of stall: M <= E with tnew=dec(E.tnew); W <= M with tnew=dec(M.tnew).
REQ-018 dec(x) SHALL equal x-1, saturating at 0.
REQ-019 A stage X SHALL match an address a when X.we=1, X.A3=a and a!=0.
REQ-020 Register 0 SHALL never match, stall or forward.
REQ-021 stall SHALL be combinational: 1 iff d_valid=1 and either of the following holds.
- Some X in {E,M} matches d_A1 with X.tnew > d_tuse_rs.
- Some X in {E,M} matches d_A2 with X.tnew > d_tuse_rt.
REQ-022 W SHALL never cause a stall.
REQ-023 fwd_d_rs SHALL select the youngest stage (E, then M, then W) that matches d_A1 with tnew=0; if none, it SHALL be 0. fwd_d_rt SHALL do the same using d_A2.
REQ-024 A younger matching stage with tnew>0 SHALL block forwarding from older stages; fwd_d SHALL be 0 in that case.
REQ-025 fwd_e_rs/rt SHALL use the same rule with E.A1/E.A2 against M, then W.
REQ-026 fwd_e_rs/rt SHALL be 0 when E.A1/E.A2 is 0 or E is a bubble.
REQ-027 Forward selects SHALL be valid in the same cycle as their inputs, with no added latency.
REQ-028 stall_cnt SHALL increment by 1 on each clk edge where stall=1, and SHALL hold at 2^CNT_W-1 without wrapping.
REQ-029 d_valid=0 SHALL force stall=0 and fwd_d_rs/rt=0.
REQ-030 A record entering E from a d_valid=0 slot SHALL be a bubble.
REQ-031 The block SHALL NOT depend on tuse values greater than 4; any tuse of 4 or more SHALL never stall.

Reset
REQ-032 While reset=0, all E/M/W records and stall_cnt SHALL be 0 immediately, without waiting for clk.
REQ-033 With records at 0, stall, fwd_d_*, fwd_e_* SHALL all read 0 during reset.
REQ-034 Reset asserted mid-stall SHALL drop stall to 0 asynchronously and discard in-flight records.
REQ-035 The first clk edge after reset=1 SHALL load E normally from the D inputs.

Verification
REQ-036 Load-use, rs: cycle0 D=lw(A3=1,tnew=3) -> cycle1 D=addu(A1=1,tuse_rs=1): stall=1, stall_cnt->1. Cycle2: stall=0, fwd_d_rs=0. Cycle3: E=addu, W=lw, fwd_e_rs=3.
REQ-037 Branch after ALU: E=addu(A3=4,tnew=1), D=beq(A1=4,tuse_rs=0) -> stall=1. Next cycle: M.tnew=0, stall=0, fwd_d_rs=2.
REQ-038 Link forward: E=jal(A3=31,tnew=0), D=jr(A1=31,tuse_rs=0) -> stall=0, fwd_d_rs=1.
REQ-039 Register 0: E=lw(A3=0), D=addu(A1=0,A2=0) -> stall=0; all fwd outputs=0.
REQ-040 Async reset: reset=0 driven between clk edges while stall=1 -> stall, stall_cnt and all fwd outputs read 0 before the next edge.
REQ-041 Saturation: CNT_W=4, hold a load-use stall for 20 cycles by re-presenting the load -> stall_cnt=15 and stays 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard detection and forwarding-select unit.
//
// Tracks the destination register and result-readiness (tnew) of the
// instructions in E, M and W. From these it stalls the D-stage instruction
// when an operand cannot be ready in time, and selects forwarding sources for
// the D and E operand reads.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   d_valid               D slot holds a real instruction (0 = bubble)
//   d_A1, d_A2, d_A3      D rs/rt read addresses, destination address
//   d_regwrite            D instruction writes d_A3
//   d_tuse_rs/rt          cycles until rs/rt are needed (>=4 never stalls)
//   d_tnew                cycles until the D result exists
//   stall                 freeze PC and F/D, inject a bubble into E
//   fwd_d_rs/rt           D operand source: 0 regfile, 1 E, 2 M, 3 W
//   fwd_e_rs/rt           E operand source: 0 pipeline reg, 2 M, 3 W
//   stall_cnt             saturating count of stalled cycles

package hazard_ctrl_pkg;

  // One in-flight producer: write enable, destination, cycles to result.
  typedef struct packed {
    logic       we;
    logic [4:0] a3;
    logic [2:0] tnew;
  } stg_t;

  // Saturating decrement of a readiness count.
  function automatic logic [2:0] dec3(input logic [2:0] x);
    return (x == 3'd0) ? 3'd0 : x - 3'd1;
  endfunction

  // A stage produces register a; r0 is hard-wired and never produced.
  function automatic logic hit(input stg_t s, input logic [4:0] a);
    return s.we && (s.a3 == a) && (a != 5'd0);
  endfunction

endpackage

// Per-operand hazard logic: stall contribution and both forward selects
// for a single source operand (rs or rt).
module hazard_ctrl_opnd
  import hazard_ctrl_pkg::*;
(
  input  logic       d_valid_i,
  input  logic [4:0] d_a_i,
  input  logic [2:0] tuse_i,
  input  stg_t       e_i,
  input  stg_t       m_i,
  input  stg_t       w_i,
  input  logic [4:0] e_a_i,
  output logic       stall_o,
  output logic [1:0] fwd_d_o,
  output logic [1:0] fwd_e_o
);

  always_comb begin
    stall_o = 1'b0;
    // W is always writing back this cycle, so only E and M can stall.
    // A tuse of 4+ is beyond any producer's reach and is ignored.
    if (d_valid_i && (tuse_i < 3'd4))
      stall_o = (hit(e_i, d_a_i) && (e_i.tnew > tuse_i)) ||
                (hit(m_i, d_a_i) && (m_i.tnew > tuse_i));
  end

  // Youngest matching producer wins; if it is not ready yet it shadows
  // older copies of the same register, so the select falls back to 0.
  always_comb begin
    fwd_d_o = 2'd0;
    if (d_valid_i) begin
      if (hit(e_i, d_a_i))      fwd_d_o = (e_i.tnew == 3'd0) ? 2'd1 : 2'd0;
      else if (hit(m_i, d_a_i)) fwd_d_o = (m_i.tnew == 3'd0) ? 2'd2 : 2'd0;
      else if (hit(w_i, d_a_i)) fwd_d_o = (w_i.tnew == 3'd0) ? 2'd3 : 2'd0;
    end
  end

  // A bubble in E carries address 0, which never hits.
  always_comb begin
    fwd_e_o = 2'd0;
    if (hit(m_i, e_a_i))      fwd_e_o = (m_i.tnew == 3'd0) ? 2'd2 : 2'd0;
    else if (hit(w_i, e_a_i)) fwd_e_o = (w_i.tnew == 3'd0) ? 2'd3 : 2'd0;
  end

endmodule

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [4:0]       d_A1,
  input  logic [4:0]       d_A2,
  input  logic [4:0]       d_A3,
  input  logic             d_regwrite,
  input  logic [2:0]       d_tuse_rs,
  input  logic [2:0]       d_tuse_rt,
  input  logic [2:0]       d_tnew,
  output logic             stall,
  output logic [1:0]       fwd_d_rs,
  output logic [1:0]       fwd_d_rt,
  output logic [1:0]       fwd_e_rs,
  output logic [1:0]       fwd_e_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int NUM_OPS = 2;  // index 0 = rs, 1 = rt

  stg_t             e_q, e_d, m_q, m_d, w_q, w_d;
  logic [4:0]       e_a1_q, e_a1_d, e_a2_q, e_a2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_OPS-1:0]      op_stall;
  logic [NUM_OPS-1:0][4:0] op_da, op_ea;
  logic [NUM_OPS-1:0][2:0] op_tuse;
  logic [NUM_OPS-1:0][1:0] op_fwd_d, op_fwd_e;

  assign op_da   = {d_A2, d_A1};
  assign op_ea   = {e_a2_q, e_a1_q};
  assign op_tuse = {d_tuse_rt, d_tuse_rs};

  genvar g;
  generate
    for (g = 0; g < NUM_OPS; g++) begin : g_op
      hazard_ctrl_opnd u_op (
        .d_valid_i (d_valid),
        .d_a_i     (op_da[g]),
        .tuse_i    (op_tuse[g]),
        .e_i       (e_q),
        .m_i       (m_q),
        .w_i       (w_q),
        .e_a_i     (op_ea[g]),
        .stall_o   (op_stall[g]),
        .fwd_d_o   (op_fwd_d[g]),
        .fwd_e_o   (op_fwd_e[g])
      );
    end
  endgenerate

  assign stall     = |op_stall;
  assign fwd_d_rs  = op_fwd_d[0];
  assign fwd_d_rt  = op_fwd_d[1];
  assign fwd_e_rs  = op_fwd_e[0];
  assign fwd_e_rt  = op_fwd_e[1];
  assign stall_cnt = cnt_q;

  always_comb begin
    // A stalled or empty D slot enters E as a full bubble.
    e_d    = '0;
    e_a1_d = 5'd0;
    e_a2_d = 5'd0;
    if (d_valid && !stall) begin
      e_d.we   = d_regwrite;
      e_d.a3   = d_A3;
      e_d.tnew = dec3(d_tnew);
      e_a1_d   = d_A1;
      e_a2_d   = d_A2;
    end
    // E, M and W drain every cycle; stall only affects what enters E.
    m_d      = e_q;
    m_d.tnew = dec3(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = dec3(m_q.tnew);
    cnt_d    = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q    <= '0;
      e_a1_q <= 5'd0;
      e_a2_q <= 5'd0;
      m_q    <= '0;
      w_q    <= '0;
      cnt_q  <= '0;
    end else begin
      e_q    <= e_d;
      e_a1_q <= e_a1_d;
      e_a2_q <= e_a2_d;
      m_q    <= m_d;
      w_q    <= w_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl. The reference keeps the in-flight instructions as
// records stamped with the absolute cycle at which their result exists, and
// derives stall / forward selects from those timestamps.
module tb_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          d_valid = 1'b0;
  logic [4:0]    d_A1 = '0, d_A2 = '0, d_A3 = '0;
  logic          d_regwrite = 1'b0;
  logic [2:0]    d_tuse_rs = '0, d_tuse_rt = '0, d_tnew = '0;
  logic          stall;
  logic [1:0]    fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic [CW-1:0] stall_cnt;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_A1(d_A1), .d_A2(d_A2), .d_A3(d_A3), .d_regwrite(d_regwrite),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_tnew(d_tnew),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit       we;
    bit [4:0] a3, a1, a2;
    int       done;   // cycle number at which the result exists
  } rec_t;

  rec_t pe, pm, pw;
  int   cyc  = 0;
  int   mcnt = 0;

  function automatic int rem(rec_t r);
    return (r.done > cyc) ? r.done - cyc : 0;
  endfunction

  function automatic bit mt(rec_t r, bit [4:0] a);
    return r.we && (r.a3 == a) && (a != 5'd0);
  endfunction

  function automatic bit m_stall();
    bit s = 0;
    if (!d_valid) return 0;
    if (d_tuse_rs < 4 && ((mt(pe, d_A1) && rem(pe) > int'(d_tuse_rs)) ||
                          (mt(pm, d_A1) && rem(pm) > int'(d_tuse_rs)))) s = 1;
    if (d_tuse_rt < 4 && ((mt(pe, d_A2) && rem(pe) > int'(d_tuse_rt)) ||
                          (mt(pm, d_A2) && rem(pm) > int'(d_tuse_rt)))) s = 1;
    return s;
  endfunction

  // Source code = stage position (E=1, M=2, W=3); first matching stage
  // decides, and it must already be ready.
  function automatic int m_fwd(bit incl_e, bit [4:0] a);
    rec_t st[3];
    st[0] = pe; st[1] = pm; st[2] = pw;
    for (int i = (incl_e ? 0 : 1); i < 3; i++)
      if (mt(st[i], a)) return (rem(st[i]) == 0) ? i + 1 : 0;
    return 0;
  endfunction

  function automatic rec_t mk_rec(bit blocked);
    rec_t r;
    r.we = 0; r.a3 = 0; r.a1 = 0; r.a2 = 0; r.done = 0;
    if (d_valid && !blocked) begin
      r.we = d_regwrite; r.a3 = d_A3; r.a1 = d_A1; r.a2 = d_A2;
      r.done = cyc + int'(d_tnew);
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pe <= mk_rec(1); pm <= mk_rec(1); pw <= mk_rec(1);
      mcnt <= 0;
    end else begin
      pw <= pm;
      pm <= pe;
      pe <= mk_rec(m_stall());
      if (m_stall() && mcnt < (1 << CW) - 1) mcnt <= mcnt + 1;
      cyc <= cyc + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_stall",     32'(stall),     32'(m_stall()));
    chk("m_stall_cnt", 32'(stall_cnt), mcnt);
    chk("m_fwd_d_rs",  32'(fwd_d_rs),  d_valid ? m_fwd(1, d_A1) : 0);
    chk("m_fwd_d_rt",  32'(fwd_d_rt),  d_valid ? m_fwd(1, d_A2) : 0);
    chk("m_fwd_e_rs",  32'(fwd_e_rs),  m_fwd(0, pe.a1));
    chk("m_fwd_e_rt",  32'(fwd_e_rt),  m_fwd(0, pe.a2));
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input bit v, input bit [4:0] a1, a2, a3, input bit rw,
                        input bit [2:0] tr, tt, tn);
    d_valid = v; d_A1 = a1; d_A2 = a2; d_A3 = a3; d_regwrite = rw;
    d_tuse_rs = tr; d_tuse_rt = tt; d_tnew = tn;
  endtask

  task automatic drv(input bit v, input bit [4:0] a1, a2, a3, input bit rw,
                     input bit [2:0] tr, tt, tn);
    @(posedge clk); #1;
    set_in(v, a1, a2, a3, rw, tr, tt, tn);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_stall"},    32'(stall),     0);
    chk({nm, "_cnt"},      32'(stall_cnt), 0);
    chk({nm, "_fwd_d_rs"}, 32'(fwd_d_rs),  0);
    chk({nm, "_fwd_d_rt"}, 32'(fwd_d_rt),  0);
    chk({nm, "_fwd_e_rs"}, 32'(fwd_e_rs),  0);
    chk({nm, "_fwd_e_rt"}, 32'(fwd_e_rt),  0);
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 reset = 1'b1;

    // load-use on rs
    drv(1, 5, 0, 1, 1, 1, 6, 3);       // lw $1
    chk("lu_c0_stall", 32'(stall), 0);
    drv(1, 1, 3, 2, 1, 1, 1, 2);       // addu uses $1
    chk("lu_c1_stall", 32'(stall), 1);
    drv(1, 1, 3, 2, 1, 1, 1, 2);       // re-presented
    chk("lu_c2_stall", 32'(stall), 0);
    chk("lu_c2_fwd_d_rs", 32'(fwd_d_rs), 0);
    chk("lu_c2_cnt", 32'(stall_cnt), 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_c3_fwd_e_rs", 32'(fwd_e_rs), 3);

    // branch after ALU
    drv(1, 7, 8, 4, 1, 1, 1, 2);       // addu $4
    drv(1, 4, 0, 0, 0, 0, 0, 0);       // beq $4
    chk("br_stall", 32'(stall), 1);
    drv(1, 4, 0, 0, 0, 0, 0, 0);
    chk("br_stall2", 32'(stall), 0);
    chk("br_fwd_d_rs", 32'(fwd_d_rs), 2);
    chk("br_cnt", 32'(stall_cnt), 2);

    // link forward
    drv(1, 0, 0, 31, 1, 6, 6, 1);      // jal
    drv(1, 31, 0, 0, 0, 0, 6, 0);      // jr $31
    chk("jr_stall", 32'(stall), 0);
    chk("jr_fwd_d_rs", 32'(fwd_d_rs), 1);

    // register 0
    drv(1, 0, 0, 0, 1, 1, 6, 3);       // lw $0
    drv(1, 0, 0, 3, 1, 1, 1, 2);
    chk("r0_stall", 32'(stall), 0);
    chk("r0_fwd_d_rs", 32'(fwd_d_rs), 0);
    chk("r0_fwd_d_rt", 32'(fwd_d_rt), 0);
    chk("r0_fwd_e_rs", 32'(fwd_e_rs), 0);
    chk("r0_fwd_e_rt", 32'(fwd_e_rt), 0);

    // tuse >= 4 never stalls, even against a far-off producer
    drv(1, 0, 0, 9, 1, 6, 6, 7);
    drv(1, 9, 9, 5, 1, 4, 5, 2);
    chk("tuse4_stall", 32'(stall), 0);
    // invalid slot: no stall, no forward, enters E as a bubble
    drv(0, 9, 9, 10, 1, 0, 0, 2);
    chk("inv_stall", 32'(stall), 0);
    chk("inv_fwd_d_rs", 32'(fwd_d_rs), 0);
    drv(1, 10, 0, 0, 0, 0, 6, 0);
    chk("inv_bubble_stall", 32'(stall), 0);
    chk("inv_bubble_fwd", 32'(fwd_d_rs), 0);

    // younger not-ready producer shadows an older ready one
    drv(1, 0, 0, 11, 1, 6, 6, 2);
    drv(1, 0, 0, 11, 1, 6, 6, 3);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 11, 0, 0, 0, 6, 6, 0);
    chk("shadow_fwd_d_rs", 32'(fwd_d_rs), 0);
    drv(1, 11, 0, 0, 0, 6, 6, 0);
    chk("unshadow_fwd_d_rs", 32'(fwd_d_rs), 3);

    // mixed traffic over a small register set; model checks every cycle
    for (int i = 0; i < 40; i++)
      drv(1'($urandom_range(0, 1)) | 1'(i % 3 != 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 3)));

    // saturation: keep re-presenting a self-dependent load
    for (int i = 0; i < 40; i++) drv(1, 12, 0, 12, 1, 0, 6, 3);
    chk("sat_cnt", 32'(stall_cnt), 15);
    for (int i = 0; i < 3; i++) drv(1, 12, 0, 12, 1, 0, 6, 3);
    chk("sat_hold", 32'(stall_cnt), 15);

    // asynchronous reset in the middle of a stall
    drv(1, 0, 0, 13, 1, 6, 6, 3);
    drv(1, 13, 0, 2, 1, 1, 6, 2);
    chk("ar_pre_stall", 32'(stall), 1);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_rst");
    set_in(1, 0, 0, 1, 1, 6, 6, 3);    // lw $1 loaded by first edge
    reset = 1'b1;
    drv(1, 1, 0, 2, 1, 1, 6, 2);
    chk("post_rst_stall", 32'(stall), 1);
    drv(1, 1, 0, 2, 1, 1, 6, 2);
    chk("post_rst_cnt", 32'(stall_cnt), 1);
    chk("post_rst_stall2", 32'(stall), 0);

    drv(0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
